seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller driving one shared external hex decoder.
// A ready/valid load port stages each word so that it appears on the display only as a complete sweep.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        page,
  output logic [3:0]  dig_nibble,
  input  logic [6:0]  seg_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int unsigned     CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]      IDX_LAST  = 3'd5;
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    READY,
    PEND,
    SWEEP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             page_q;
  logic [31:0]      disp_val;
  logic [31:0]      pend_val;
  logic [6:0]       hex_q [6];

  logic             slot_end;
  logic             wrap;
  logic             blank_slot;
  logic [3:0]       nib_sel;
  logic [3:0]       nib_next;

  // Page 1 shows only the top byte on digits 0..1; the remaining digits are forced blank.
  always_comb begin
    slot_end   = (cnt == CNT_MAX);
    wrap       = slot_end && (idx == IDX_LAST);
    blank_slot = page_q && (idx >= 3'd2);
    nib_sel    = page_q ? ({1'b0, idx} + 4'd6) : {1'b0, idx};
    nib_next   = blank_slot ? 4'h0 : 4'(disp_val >> {nib_sel, 2'b00});
  end

  // Scan timing, decoder feed and per-digit capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      page_q     <= 1'b0;
      dig_nibble <= 4'h0;
      // NOTE: hex_q is a six-entry register bank, not a RAM, so it takes the reset too; the digits must read blank out of reset.
      for (int k = 0; k < 6; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every term below sees the pre-edge cnt/idx/page_q, never a half-updated mix.
      cnt        <= slot_end ? '0 : cnt + CNT_ONE;
      dig_nibble <= nib_next;
      if (slot_end) begin
        idx    <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        page_q <= page;
        for (int k = 0; k < 6; k++) begin
          if (idx == 3'(k)) hex_q[k] <= blank_slot ? SEG_BLANK : seg_in;
        end
      end
    end
  end

  // Load staging: a word waits in PEND for a sweep start, then owns one full sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= READY;
      load_ready <= 1'b1;
      pend_val   <= '0;
      disp_val   <= '0;
    end else begin
      unique case (state)
        READY: begin
          if (load_valid) begin
            pend_val   <= load_data;
            state      <= PEND;
            load_ready <= 1'b0;
          end
        end
        PEND: begin
          if (wrap) begin
            disp_val <= pend_val;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          if (wrap) begin
            state      <= READY;
            load_ready <= 1'b1;
          end
        end
        default: begin
          state      <= READY;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed and random loads compared every cycle
// against an edge-counting reference model of the display and the load handshake.
module tb_seg7_scan_ctrl;

  localparam int         SCAN_DIV  = 4;
  localparam int         SWEEP_CYC = 6 * SCAN_DIV;
  localparam logic [6:0] BLANK     = 7'b1111111;
  localparam logic [6:0] ZERO      = 7'b1000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        page;
  logic [3:0]  dig_nibble;
  logic [6:0]  seg_in;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  hex_w [6];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .page      (page),
    .dig_nibble(dig_nibble),
    .seg_in    (seg_in),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .hex4      (hex4),
    .hex5      (hex5)
  );

  assign hex_w[0] = hex0;
  assign hex_w[1] = hex1;
  assign hex_w[2] = hex2;
  assign hex_w[3] = hex3;
  assign hex_w[4] = hex4;
  assign hex_w[5] = hex5;

  // External active-low hex decoder (segments gfedcba).
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign seg_in = seg_of(dig_nibble);

  // What digit k shows for a displayed word under a given page setting.
  function automatic logic [6:0] exp_hex(input logic [31:0] val, input logic pg, input int k);
    logic [31:0] sh;
    if (pg && k >= 2) return BLANK;
    sh = pg ? (val >> (24 + 4 * k)) : (val >> (4 * k));
    return seg_of(sh[3:0]);
  endfunction

  // Reference model: positions are derived from the number of edges since reset release.
  int          e_n;
  int          apply_e;
  int          done_e;
  int          s_idx;
  logic        m_ready;
  logic        m_sweep;
  logic        m_page;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  logic [6:0]  m_hex [6];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_n = 0; apply_e = 0; done_e = 0;
      m_ready = 1'b1; m_sweep = 1'b0; m_page = 1'b0;
      m_disp = '0; m_pend = '0;
      for (int k = 0; k < 6; k++) m_hex[k] = BLANK;
    end else begin
      e_n++;
      if ((e_n - 1) % SCAN_DIV == SCAN_DIV - 1) begin
        s_idx = ((e_n - 1) / SCAN_DIV) % 6;
        m_hex[s_idx] = exp_hex(m_disp, m_page, s_idx);
        m_page = page;
      end
      if (m_ready) begin
        if (load_valid) begin
          m_pend  = load_data;
          m_ready = 1'b0;
          apply_e = (e_n / SWEEP_CYC + 1) * SWEEP_CYC;
          done_e  = apply_e + SWEEP_CYC;
        end
      end else if (e_n == apply_e) begin
        m_disp  = m_pend;
        m_sweep = 1'b1;
      end else if (e_n == done_e) begin
        m_ready = 1'b1;
        m_sweep = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, got, exp, e_n);
    end
  endtask

  // One clock; compare handshake and every digit against the model.
  task automatic tick();
    @(negedge clk);
    check("load_ready", {31'b0, load_ready}, {31'b0, m_ready});
    for (int k = 0; k < 6; k++) check($sformatf("hex%0d", k), {25'b0, hex_w[k]}, {25'b0, m_hex[k]});
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!m_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("ready_timeout", {31'b0, m_ready}, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] val, input logic pg);
    page       = pg;
    load_valid = 1'b1;
    load_data  = val;
    tick();
    load_valid = 1'b0;
    load_data  = $urandom;
    check("ready_drop", {31'b0, load_ready}, 32'd0);
    wait_ready();
  endtask

  task automatic check_digits(input string tag, input logic [31:0] val, input logic pg);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s_hex%0d", tag, k), {25'b0, hex_w[k]}, {25'b0, exp_hex(val, pg, k)});
  endtask

  logic [31:0] old_val, new_val, first_word, second_word, rnd;
  int          guard, gap;

  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    page       = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, load_ready}, 32'd1);
    check("rst_nibble", {28'b0, dig_nibble}, 32'd0);
    for (int k = 0; k < 6; k++) check($sformatf("rst_hex%0d", k), {25'b0, hex_w[k]}, {25'b0, BLANK});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle sweep shows zero everywhere.
    repeat (SWEEP_CYC) tick();
    for (int k = 0; k < 6; k++) check($sformatf("idle_hex%0d", k), {25'b0, hex_w[k]}, {25'b0, ZERO});

    // Page 0 load.
    do_load(32'h00ABCDEF, 1'b0);
    check("abc_hex0", {25'b0, hex0}, {25'b0, 7'b0001110});
    check("abc_hex1", {25'b0, hex1}, {25'b0, 7'b0000110});
    check("abc_hex2", {25'b0, hex2}, {25'b0, 7'b0100001});
    check("abc_hex3", {25'b0, hex3}, {25'b0, 7'b1000110});
    check("abc_hex4", {25'b0, hex4}, {25'b0, 7'b0000011});
    check("abc_hex5", {25'b0, hex5}, {25'b0, 7'b0001000});

    // Page 1 load.
    do_load(32'h12000000, 1'b1);
    check("pg1_hex0", {25'b0, hex0}, {25'b0, 7'b0100100});
    check("pg1_hex1", {25'b0, hex1}, {25'b0, 7'b1111001});
    for (int k = 2; k < 6; k++) check($sformatf("pg1_hex%0d", k), {25'b0, hex_w[k]}, {25'b0, BLANK});

    // Accept exactly on the wrap edge: value waits a full sweep before it is applied.
    page = 1'b0;
    old_val = 32'h12000000;
    repeat (SWEEP_CYC) tick();
    guard = 0;
    while (e_n % SWEEP_CYC != SWEEP_CYC - 1 && guard < 100) begin
      tick();
      guard++;
    end
    new_val    = 32'h3C5A9F17;
    load_valid = 1'b1;
    load_data  = new_val;
    tick();
    load_valid = 1'b0;
    check("wrap_ready_drop", {31'b0, load_ready}, 32'd0);
    repeat (SWEEP_CYC) tick();
    check_digits("wrap_old", old_val, 1'b0);
    wait_ready();
    check_digits("wrap_new", new_val, 1'b0);

    // Held valid with changing data: only the word offered while ready is taken.
    first_word = $urandom;
    load_valid = 1'b1;
    load_data  = first_word;
    tick();
    check("hold_busy", {31'b0, load_ready}, 32'd0);
    guard = 0;
    while (!m_ready && guard < 200) begin
      load_data = $urandom;
      tick();
      guard++;
    end
    check("hold_timeout", {31'b0, m_ready}, 32'd1);
    check_digits("hold_first", first_word, 1'b0);
    second_word = $urandom;
    load_data   = second_word;
    tick();
    load_valid = 1'b0;
    check("hold_second_acc", {31'b0, load_ready}, 32'd0);
    wait_ready();
    check_digits("hold_second", second_word, 1'b0);

    // Random loads with random page flips, including mid-flight on odd rounds.
    for (int r = 0; r < 6; r++) begin
      gap = $urandom_range(0, 30);
      repeat (gap) begin
        if ($urandom_range(0, 3) == 0) page = ~page;
        tick();
      end
      rnd        = $urandom;
      load_valid = 1'b1;
      load_data  = rnd;
      tick();
      load_valid = 1'b0;
      check("rnd_ready_drop", {31'b0, load_ready}, 32'd0);
      guard = 0;
      while (!m_ready && guard < 200) begin
        if (r % 2 == 1 && $urandom_range(0, 7) == 0) page = ~page;
        tick();
        guard++;
      end
      check("rnd_timeout", {31'b0, m_ready}, 32'd1);
    end

    // Reset during SWEEP discards the value and blanks the digits at once.
    page       = 1'b0;
    repeat (SWEEP_CYC) tick();
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    tick();
    load_valid = 1'b0;
    guard = 0;
    while (!m_sweep && guard < 100) begin
      tick();
      guard++;
    end
    check("sweep_reached", {31'b0, m_sweep}, 32'd1);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, load_ready}, 32'd1);
    for (int k = 0; k < 6; k++) check($sformatf("midrst_hex%0d", k), {25'b0, hex_w[k]}, {25'b0, BLANK});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * SWEEP_CYC) tick();
    for (int k = 0; k < 6; k++) check($sformatf("postrst_hex%0d", k), {25'b0, hex_w[k]}, {25'b0, ZERO});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded its time limit at edge %0d", e_n);
    $fatal(1, "watchdog expired");
  end

endmodule
